// File: rtl/cordic_nco_ctrl_pkg.sv
// Shared constants and types for the CORDIC NCO sequencer and its rotator.
package cordic_nco_ctrl_pkg;

  // Angle/sample width: 0..2^WIDTH-1 covers one full turn.
  localparam int CORDIC_WIDTH   = 12;
  // Quadrant register + (WIDTH-1) iterations + output register.
  localparam int CORDIC_LATENCY = CORDIC_WIDTH + 1;
  localparam int CORDIC_CNT_W   = 16;
  // 2047/K with K ~ 1.6468, so the rotated vector lands at full scale.
  localparam int CORDIC_X_INIT  = 'h4DB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // atan(2^-i) scaled so that 2^WIDTH is one full turn; shared with the rotator.
  localparam int ATAN_LUT [CORDIC_WIDTH] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  function automatic logic [CORDIC_WIDTH-1:0] atan_entry(input int idx);
    return CORDIC_WIDTH'(ATAN_LUT[idx]);
  endfunction

endpackage

// File: rtl/cordic_nco_ctrl_if.sv
// Configuration handshake between a host and the NCO sequencer.
interface cordic_nco_ctrl_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_fword;
  logic [WIDTH-1:0] cfg_phase;
  logic [CNT_W-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_fword, cfg_phase, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_fword, cfg_phase, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/cordic_nco_ctrl_valid_pipe.sv
// Fixed-depth {valid,last} delay line that follows samples through the rotator.
module cordic_nco_ctrl_valid_pipe #(
  parameter int DEPTH = 13
) (
  input  logic clk,
  input  logic clr,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [1:0] q;
    if (gi == 0) begin : g_head
      // First stage captures the flags registered alongside the angle.
      always_ff @(posedge clk) begin
        if (clr) q <= 2'b00;
        else     q <= {valid_i, last_i};
      end
    end else begin : g_tail
      // Each later stage shifts the previous one by a cycle.
      always_ff @(posedge clk) begin
        if (clr) q <= 2'b00;
        else     q <= g_stage[gi-1].q;
      end
    end
  end

  assign valid_o = g_stage[DEPTH-1].q[1];
  assign last_o  = g_stage[DEPTH-1].q[0];

endmodule

// File: rtl/cordic_nco_ctrl.sv
// Angle sequencer for the pipelined CORDIC rotator: phase accumulator,
// burst/continuous control and valid/last tracking through the rotator.
module cordic_nco_ctrl
  import cordic_nco_ctrl_pkg::*;
#(
  parameter int WIDTH   = CORDIC_WIDTH,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int CNT_W   = CORDIC_CNT_W,
  parameter int X_INIT  = CORDIC_X_INIT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cordic_resetn,
  cordic_nco_ctrl_if.slave  cfg,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [WIDTH-1:0]  x_start,
  output logic [WIDTH-1:0]  y_start,
  output logic [WIDTH-1:0]  angle,
  output logic              sample_valid,
  output logic              sample_last,
  output logic              done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   angle_q, angle_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [WIDTH-1:0]   fword_q, phase_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   x_q;
  logic               cfg_accept;
  logic               terminal;
  logic               last_issue;
  logic               pipe_valid, pipe_last;

  assign cordic_resetn = ~reset;
  assign cfg.cfg_ready = (state_q == IDLE) && !reset;
  assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;

  // issued_q counts the sample currently on angle, so equality marks the final one.
  assign terminal   = (count_q != '0) && (issued_q == count_q);
  assign last_issue = (state_q == RUN) && (terminal || stop);

  // Next-state, accumulator and issue-counter logic.
  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    issued_d = issued_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          angle_d  = cfg_accept ? cfg.cfg_phase : phase_q;
          issued_d = CNT_W'(1);
        end
      end
      RUN: begin
        if (terminal || stop) begin
          // Hold the final angle while the rotator drains.
          state_d = DRAIN;
        end else begin
          angle_d  = angle_q + fword_q;
          issued_d = issued_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (pipe_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator, counter and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      angle_q  <= '0;
      issued_q <= '0;
      fword_q  <= '0;
      phase_q  <= '0;
      count_q  <= '0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      issued_q <= issued_d;
      x_q      <= WIDTH'(X_INIT);
      if (cfg_accept) begin
        fword_q <= cfg.cfg_fword;
        phase_q <= cfg.cfg_phase;
        count_q <= cfg.cfg_count;
      end
    end
  end

  // Flags enter the delay line in the same cycle their angle is presented.
  cordic_nco_ctrl_valid_pipe #(.DEPTH(LATENCY)) u_valid_pipe (
    .clk     (clk),
    .clr     (reset),
    .valid_i (state_q == RUN),
    .last_i  (last_issue),
    .valid_o (pipe_valid),
    .last_o  (pipe_last)
  );

  assign angle        = angle_q;
  assign x_start      = x_q;
  assign y_start      = '0;
  assign busy         = (state_q != IDLE);
  assign sample_valid = pipe_valid;
  assign sample_last  = pipe_last;
  assign done         = (state_q == DRAIN) && pipe_last;

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
// Self-checking bench for cordic_nco_ctrl: directed and random bursts against
// an arithmetic model of the expected angle/flag timeline.
module tb_cordic_nco_ctrl;

  localparam int W   = 12;
  localparam int CW  = 16;
  localparam int LAT = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cordic_resetn;
  logic          start, stop;
  logic          busy;
  logic [W-1:0]  x_start, y_start, angle;
  logic          sample_valid, sample_last, done;

  int tests = 0;
  int fails = 0;

  // Configuration the model believes the DUT holds.
  int fw_m = 0, ph_m = 0, cnt_m = 0;

  cordic_nco_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cfg_if ();

  cordic_nco_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cordic_resetn (cordic_resetn),
    .cfg           (cfg_if),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .x_start       (x_start),
    .y_start       (y_start),
    .angle         (angle),
    .sample_valid  (sample_valid),
    .sample_last   (sample_last),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_angle"},  int'(angle), 0);
    check({tag, "_xstart"}, int'(x_start), 0);
    check({tag, "_ystart"}, int'(y_start), 0);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_svalid"}, int'(sample_valid), 0);
    check({tag, "_slast"},  int'(sample_last), 0);
    check({tag, "_done"},   int'(done), 0);
    check({tag, "_ready"},  int'(cfg_if.cfg_ready), 0);
    check({tag, "_resetn"}, int'(cordic_resetn), 0);
  endtask

  // One run: the model expects angle(k) = phase + k*fword mod 2^W for the
  // first n cycles, then n sample_valid cycles starting LAT cycles later.
  task automatic run_burst(input int fw, input int ph, input int cnt, input int stop_at,
                           input bit load, input bit noise);
    int n;
    int fails_before;
    if (load) begin
      fw_m = fw; ph_m = ph; cnt_m = cnt;
    end
    if (cnt_m != 0 && (stop_at == 0 || cnt_m < stop_at)) n = cnt_m;
    else n = stop_at;
    fails_before = fails;

    @(negedge clk);
    check("idle_busy",  int'(busy), 0);
    check("idle_ready", int'(cfg_if.cfg_ready), 1);
    check("idle_x",     int'(x_start), 'h4DB);
    check("idle_y",     int'(y_start), 0);
    cfg_if.cfg_valid = load;
    if (load) begin
      cfg_if.cfg_fword = W'(fw);
      cfg_if.cfg_phase = W'(ph);
      cfg_if.cfg_count = CW'(cnt);
    end
    start = 1'b1;
    @(posedge clk);

    for (int k = 0; k <= LAT + n; k++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      stop = 1'b0;
      if (k < n) check($sformatf("angle_k%0d", k), int'(angle), (ph_m + k * fw_m) % (1 << W));
      check($sformatf("svalid_k%0d", k), int'(sample_valid), int'(k >= LAT && k < LAT + n));
      check($sformatf("slast_k%0d", k),  int'(sample_last),  int'(k == LAT + n - 1));
      check($sformatf("done_k%0d", k),   int'(done),         int'(k == LAT + n - 1));
      check($sformatf("busy_k%0d", k),   int'(busy),         int'(k <= LAT + n - 1));
      check($sformatf("ready_k%0d", k),  int'(cfg_if.cfg_ready), int'(k > LAT + n - 1));
      // Stray start/cfg while busy must be ignored; stray stop only after the last issue.
      if (noise && k < LAT + n - 1) begin
        start = 1'($urandom_range(0, 1));
        cfg_if.cfg_valid = 1'($urandom_range(0, 1));
        cfg_if.cfg_fword = W'($urandom);
        cfg_if.cfg_phase = W'($urandom);
        cfg_if.cfg_count = CW'($urandom_range(1, 9));
        if (k >= n) stop = 1'($urandom_range(0, 1));
      end
      if (stop_at != 0 && k == stop_at - 1) stop = 1'b1;
    end
    start = 1'b0;
    stop = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    $display("[TB] burst fw=%03h ph=%03h cnt=%0d stop_at=%0d load=%0b -> %0d samples, %0d new errors",
             fw_m, ph_m, cnt_m, stop_at, load, n, fails - fails_before);
  endtask

  initial begin
    int rfw, rph, rcnt, rstop;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_fword = '0;
    cfg_if.cfg_phase = '0;
    cfg_if.cfg_count = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check("post_x",      int'(x_start), 'h4DB);
    check("post_y",      int'(y_start), 0);
    check("post_ready",  int'(cfg_if.cfg_ready), 1);
    check("post_resetn", int'(cordic_resetn), 1);

    run_burst('h100, 'h000, 4, 0, 1'b1, 1'b0);
    run_burst('hC00, 'h800, 3, 0, 1'b1, 1'b0);
    run_burst('h010, 'h020, 0, 10, 1'b1, 1'b0);
    run_burst('h123, 'h456, 5, 5, 1'b1, 1'b0);
    run_burst('h033, 'h100, 6, 0, 1'b1, 1'b1);
    run_burst('h7FF, 'hFFF, 1, 0, 1'b1, 1'b0);
    run_burst(0, 0, 0, 0, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      rfw   = int'($urandom_range(0, (1 << W) - 1));
      rph   = int'($urandom_range(0, (1 << W) - 1));
      rcnt  = int'($urandom_range(0, 8));
      rstop = (rcnt == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 10));
      run_burst(rfw, rph, rcnt, rstop, 1'b1, 1'b1);
    end

    // Reset in the middle of a continuous run.
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_fword = W'('h040);
    cfg_if.cfg_phase = W'('h200);
    cfg_if.cfg_count = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_busy", int'(busy), 1);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("midrst%0d", c));
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("rel_svalid_c%0d", c), int'(sample_valid), 0);
      check($sformatf("rel_done_c%0d", c),   int'(done), 0);
      check($sformatf("rel_busy_c%0d", c),   int'(busy), 0);
    end
    $display("[TB] mid-run reset checked, %0d errors so far", fails);

    // Stored config was cleared by reset: a start without a new config begins at phase 0.
    fw_m = 0; ph_m = 0; cnt_m = 0;
    run_burst(0, 0, 0, 3, 1'b0, 1'b0);
    run_burst('h0AB, 'h321, 2, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_nco_ctrl.md
# cordic_nco_ctrl

Upstream sequencer for the 12-bit pipelined CORDIC rotator. It generates one rotation angle per clock from a programmable phase accumulator and presents a fixed gain-compensated start vector. A delay line tracks valid and last flags through the rotator's fixed latency, so the consumer can qualify the SINout and COSout streams. Each run is either a counted burst or continuous until stopped.

## Interface
Parameters:
- WIDTH, 12, angle/sample width; 0..2^WIDTH-1 maps to 0..2pi
- LATENCY, 13, cycles from angle presented to matching SINout/COSout (1 quadrant reg + WIDTH-1 iterations + 1 output reg)
- CNT_W, 16, burst counter width
- X_INIT, 'h4DB, x_start value (2047/K, K~1.6468)

Ports (clk, reset first):
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- cordic_resetn  out  1  = ~reset (combinational), drives rotator resetn
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high only in IDLE
- cfg_fword  in  WIDTH  phase increment per sample
- cfg_phase  in  WIDTH  start phase
- cfg_count  in  CNT_W  samples per burst; 0 = continuous
- start  in  1  level/pulse, sampled in IDLE only
- stop  in  1  ends RUN after current issue
- busy  out  1  high in RUN and DRAIN
- x_start, y_start  out  WIDTH  rotator start vector
- angle  out  WIDTH  registered rotator angle
- sample_valid  out  1  rotator output at this cycle is a real sample
- sample_last  out  1  with sample_valid, final sample of run
- done  out  1  one-cycle pulse on DRAIN->IDLE

## Operation
- Reset values: cfg_ready 0 during reset then 1, angle 0, x_start 0, y_start 0, busy 0, sample_valid 0, sample_last 0, done 0, accumulator 0, stored config 0, delay line cleared.
- After reset, x_start = X_INIT, y_start = 0 (constant).
- States: IDLE, RUN, DRAIN.
- IDLE: cfg_valid&cfg_ready latches fword/phase/count. start -> RUN; angle <= phase (new cfg if accepted same cycle), issue=1, issued=1.
- RUN: each cycle angle <= angle + fword, mod 2^WIDTH (wrap, no saturation), issue=1, issued++. Exit to DRAIN on the edge where issued==count (count!=0) or stop=1; the cycle's issue flagged last. stop and terminal count together: single last, no extra sample. start and cfg_valid ignored (cfg_ready=0).
- DRAIN: issue=0, angle holds. After LATENCY cycles (last flag emerges) -> IDLE, done=1 that cycle.
- count=1: exactly one sample; count=0: runs until stop; continuous issued counter wraps harmlessly.
- stop in IDLE/DRAIN ignored.
- Reset mid-RUN/DRAIN: immediate return to IDLE, delay line flushed, no sample_valid, no done.

## Timing
- cycle n = angle stable between edges n and n+1; flags registered with angle.
- Rotator captures at edge n+1; result visible in cycle n+LATENCY; sample_valid/sample_last asserted in cycle n+LATENCY.
- start seen at edge e -> first angle cycle e (visible after e); first sample_valid LATENCY cycles later; burst of N gives N contiguous sample_valid cycles.
- done asserts in the same cycle as sample_last+1? No: done asserts in the cycle sample_last is high, busy drops next cycle.
- Back-to-back runs: new start accepted the cycle after done; min gap IDLE 1 cycle.

## Structure
- Package cordic_pkg: WIDTH, LATENCY, X_INIT, state enum (IDLE/RUN/DRAIN), atan table constants shared with rotator.
- Sub-module cordic_valid_pipe: LATENCY-deep 2-bit shift register {valid,last} with synchronous clear; reused by downstream consumers.
- Top: FSM, accumulator, counter, cfg registers.

## Test plan
- Reset hold 3 cycles mid-RUN -> all outputs at reset values, no done, sample_valid low 20 cycles after release.
- cfg fword=256, phase=0, count=4, start -> angle 0,256,512,768; sample_valid cycles n+13..n+16; last on 4th; done same cycle; SINout ~0,783,1447,1891.
- fword='hC00, phase='h800, count=3 -> angle 'h800,'h400,'h000 (wrap verified).
- count=0, stop 10 cycles after start -> exactly 10 sample_valid, last on 10th.
- stop coincident with terminal count of count=5 -> 5 samples, one last, one done.
- start and cfg_valid same IDLE cycle with phase='h100 -> first angle 'h100; start during RUN ignored.
